// File: rtl/simon_io_pkg.sv
// ---------------------------------------------------------------------------
// simon_io_pkg
// Shared constants for the Simon game I/O blocks: memory-mapped addresses of
// the peripherals on the CPU data bus, the default button count, and the
// default debounce length, which is derived from the 50 MHz system clock.
// No ports (package).
// ---------------------------------------------------------------------------
package simon_io_pkg;

    // Word addresses decoded on the CPU data-read path
    localparam logic [31:0] BTN_ADDR  = 32'd1000;
    localparam logic [31:0] RAND_ADDR = 32'd2000;

    localparam int DEFAULT_NUM_BTN = 4;

    // 5 ms of stable input at 50 MHz
    localparam int CLK_FREQ_HZ             = 50_000_000;
    localparam int DEBOUNCE_TIME_US        = 5000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1_000_000) * DEBOUNCE_TIME_US;

    // Width of a counter that must reach cycles-1; never narrower than 1 bit
    function automatic int counter_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: two-flop synchroniser, hold-time debounce
// counter, stable level flop and a one-cycle pulse on each accepted press.
//
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous, active-low reset
//   raw    in   raw asynchronous button pin, active-high
//   level  out  debounced button level
//   press  out  one-cycle pulse, asserted on the same edge that level rises
// ---------------------------------------------------------------------------
module btn_debounce
    import simon_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W   = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic             stable;
    logic [CNT_W-1:0] count;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any return to agreement (a glitch) restarts it from 0.
    // The press pulse is registered alongside stable so both appear together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            stable    <= 1'b0;
            count     <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
            press     <= 1'b0;
            if (sync == stable) begin
                count <= '0;
            end else if (count == CNT_MAX) begin
                stable <= sync;
                count  <= '0;
                press  <= sync;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/simon_button_io.sv
// ---------------------------------------------------------------------------
// simon_button_io
// Button input conditioner sitting on the CPU data-read path. Each of the
// NUM_BTN buttons is synchronised and debounced; every accepted press sets a
// sticky pending bit which the CPU reads at BTN_ADDR. A read clears exactly
// the bits it returned, so a press arriving in the same cycle survives.
//
// Optional build macro SIMON_BTN_LEVEL_EN: when defined, the debounced
// levels are also visible in rd_data[2*NUM_BTN-1:NUM_BTN] (read-only, never
// cleared). When undefined those bits read 0.
//
// Ports:
//   clock      in   system (CPU) clock
//   reset      in   asynchronous, active-low reset
//   btn_raw    in   raw button pins, active-high
//   mem_addr   in   CPU data word address
//   rd_en      in   CPU load strobe, one cycle per load
//   rd_data    out  read data for the CPU mux (valid on address alone)
//   btn_level  out  debounced levels
//   btn_press  out  one-cycle pulse per debounced rising edge
// ---------------------------------------------------------------------------
module simon_button_io
    import simon_io_pkg::*;
#(
    parameter int          NUM_BTN         = DEFAULT_NUM_BTN,
    parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [31:0] BTN_ADDR        = simon_io_pkg::BTN_ADDR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [31:0]        mem_addr,
    input  logic               rd_en,
    output logic [31:0]        rd_data,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press
);

    logic               addr_match;
    logic               hit;
    logic [NUM_BTN-1:0] pending;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    assign addr_match = (mem_addr == BTN_ADDR);
    assign hit        = rd_en & addr_match;

    // Read data depends only on the address so the CPU mux sees it before
    // the load strobe is qualified.
    always_comb begin
        rd_data = '0;
        if (addr_match) begin
            rd_data[NUM_BTN-1:0] = pending;
`ifdef SIMON_BTN_LEVEL_EN
            rd_data[2*NUM_BTN-1:NUM_BTN] = btn_level;
`endif
        end
    end

    // Clear only what the read returned, then OR in new presses so a press
    // colliding with a read is kept for the next read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (hit ? (pending & ~rd_data[NUM_BTN-1:0]) : pending) | btn_press;
        end
    end

endmodule

// File: tb/tb_simon_button_io.sv
// ---------------------------------------------------------------------------
// tb_simon_button_io
// Self-checking bench for simon_button_io with a 4-cycle debounce. A vector
// table covers a clean press, back-to-back reads and a maximum-length glitch;
// hand-written sequences cover read/press collision, wrong-address reads,
// repeated presses, reset mid-debounce and the optional level bits.
// ---------------------------------------------------------------------------
module tb_simon_button_io;

    localparam logic [31:0] A_BTN  = 32'd1000;
    localparam logic [31:0] A_RAND = 32'd2000;

`ifdef SIMON_BTN_LEVEL_EN
    localparam logic [3:0] LVL_MASK = 4'hF;
`else
    localparam logic [3:0] LVL_MASK = 4'h0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  btn_raw;
    logic [31:0] mem_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [3:0]  btn_level;
    logic [3:0]  btn_press;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0]  raw;
        logic [31:0] addr;
        logic        en;
        logic [3:0]  lvl;
        logic [3:0]  press;
        logic [3:0]  pend;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    simon_button_io #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(4),
        .BTN_ADDR       (32'd1000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .mem_addr (mem_addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    // Expected read word: pending in the low nibble, levels above it only in
    // the level-enabled build, and nothing at all off-address.
    function automatic logic [31:0] expRd(input logic [3:0] pend, input logic [3:0] lvl,
                                          input logic [31:0] addr);
        logic [31:0] r;
        r = 32'h0;
        if (addr == A_BTN) begin
            r[3:0] = pend;
            r[7:4] = lvl & LVL_MASK;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later,
    // well away from the rising edge that updates the DUT.
    task automatic applyStimulus(input logic [3:0] raw, input logic [31:0] addr,
                                 input logic en);
        @(negedge clock);
        btn_raw  = raw;
        mem_addr = addr;
        rd_en    = en;
        #1;
    endtask

    task automatic waitPress(input int idx, input int exp_cycles, input string name);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (n < 20 && !found) begin
            @(negedge clock);
            #1;
            n++;
            if (btn_press[idx]) found = 1;
        end
        checkOutput(name, 32'(n), found ? 32'(exp_cycles) : 32'hFFFF_FFFF);
    endtask

    task automatic idle(input int cycles, input logic [3:0] raw);
        for (int i = 0; i < cycles; i++) applyStimulus(raw, 32'd0, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        btn_raw  = 4'h0;
        mem_addr = 32'd0;
        rd_en    = 1'b0;

        // ---- Reset: raw toggling must not reach any output ----
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 4'hF : 4'h0, A_BTN, 1'b1);
            checkOutput($sformatf("reset level %0d", i), 32'(btn_level), 32'h0);
            checkOutput($sformatf("reset rd %0d", i), rd_data, 32'h0);
        end
        @(negedge clock);
        btn_raw = 4'h0;
        reset   = 1'b1;
        idle(3, 4'h0);
        checkOutput("post-reset level", 32'(btn_level), 32'h0);
        checkOutput("post-reset press", 32'(btn_press), 32'h0);
        applyStimulus(4'h0, A_BTN, 1'b1);
        checkOutput("post-reset rd", rd_data, 32'h0);

        // ---- Vector table: clean press of btn 2, reads, 3-cycle glitch on btn 0 ----
        vecs.push_back('{4'h4, 32'd0, 1'b0, 4'h0, 4'h0, 4'h0});
        for (int i = 1; i <= 5; i++) vecs.push_back('{4'h4, 32'd0, 1'b0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{4'h4, 32'd0, 1'b0, 4'h4, 4'h4, 4'h0});
        vecs.push_back('{4'h4, A_BTN, 1'b1, 4'h4, 4'h0, 4'h4});
        vecs.push_back('{4'h4, A_BTN, 1'b1, 4'h4, 4'h0, 4'h0});
        for (int i = 0; i < 3; i++) vecs.push_back('{4'h5, 32'd0, 1'b0, 4'h4, 4'h0, 4'h0});
        for (int i = 0; i < 4; i++) vecs.push_back('{4'h4, 32'd0, 1'b0, 4'h4, 4'h0, 4'h0});
        vecs.push_back('{4'h4, A_BTN, 1'b1, 4'h4, 4'h0, 4'h0});
        vecs.push_back('{4'h4, A_BTN, 1'b0, 4'h4, 4'h0, 4'h0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].raw, vecs[i].addr, vecs[i].en);
            checkOutput($sformatf("row%0d level", i), 32'(btn_level), 32'(vecs[i].lvl));
            checkOutput($sformatf("row%0d press", i), 32'(btn_press), 32'(vecs[i].press));
            checkOutput($sformatf("row%0d rd", i), rd_data,
                        expRd(vecs[i].pend, vecs[i].lvl, vecs[i].addr));
        end

        // ---- Collision: btn1 press lands in the same cycle as a read of 0x1 ----
        applyStimulus(4'h5, 32'd0, 1'b0);
        waitPress(0, 6, "btn0 latency");
        applyStimulus(4'h7, 32'd0, 1'b0);
        checkOutput("btn0 single pulse", 32'(btn_press), 32'h0);
        waitPress(1, 6, "btn1 latency");
        mem_addr = A_BTN;
        rd_en    = 1'b1;
        #1;
        checkOutput("collision rd", rd_data, expRd(4'h1, 4'h7, A_BTN));
        applyStimulus(4'h7, A_BTN, 1'b1);
        checkOutput("collision next rd", rd_data, expRd(4'h2, 4'h7, A_BTN));
        applyStimulus(4'h7, A_BTN, 1'b1);
        checkOutput("collision drained", rd_data, expRd(4'h0, 4'h7, A_BTN));

        // ---- Release everything: no press events on release ----
        applyStimulus(4'h0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'h0, 32'd0, 1'b0);
            checkOutput($sformatf("release press %0d", i), 32'(btn_press), 32'h0);
        end
        checkOutput("released level", 32'(btn_level), 32'h0);

        // ---- Wrong address and level bits with btn 3 ----
        applyStimulus(4'h8, 32'd0, 1'b0);
        waitPress(3, 6, "btn3 latency");
        applyStimulus(4'h8, A_RAND, 1'b1);
        checkOutput("wrong addr rd", rd_data, 32'h0);
        applyStimulus(4'h8, A_BTN, 1'b0);
        checkOutput("unstrobed rd", rd_data, expRd(4'h8, 4'h8, A_BTN));
        applyStimulus(4'h8, A_BTN, 1'b1);
        checkOutput("btn3 first rd", rd_data, expRd(4'h8, 4'h8, A_BTN));
        applyStimulus(4'h8, A_BTN, 1'b1);
        checkOutput("btn3 second rd", rd_data, expRd(4'h0, 4'h8, A_BTN));

        // ---- Two presses of btn 3 without a read collapse into one bit ----
        idle(9, 4'h0);
        applyStimulus(4'h8, 32'd0, 1'b0);
        waitPress(3, 6, "repeat press 1");
        idle(9, 4'h0);
        applyStimulus(4'h8, 32'd0, 1'b0);
        waitPress(3, 6, "repeat press 2");
        applyStimulus(4'h8, A_BTN, 1'b1);
        checkOutput("collapsed rd", rd_data, expRd(4'h8, 4'h8, A_BTN));
        applyStimulus(4'h8, A_BTN, 1'b1);
        checkOutput("collapsed drained", rd_data, expRd(4'h0, 4'h8, A_BTN));

        // ---- Reset mid-debounce of btn 0 while btn 3 is held ----
        applyStimulus(4'h9, 32'd0, 1'b0);
        idle(2, 4'h9);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("mid reset level", 32'(btn_level), 32'h0);
        applyStimulus(4'h9, A_BTN, 1'b1);
        checkOutput("mid reset rd", rd_data, 32'h0);
        @(negedge clock);
        reset    = 1'b1;
        mem_addr = 32'd0;
        rd_en    = 1'b0;
        #1;
        waitPress(0, 6, "held after reset");
        checkOutput("held after reset press", 32'(btn_press), 32'h9);
        applyStimulus(4'h9, A_BTN, 1'b1);
        checkOutput("held after reset rd", rd_data, expRd(4'h9, 4'h9, A_BTN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
